// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Hazard detection and EX-stage operand forwarding control for the RV32I
//   pipeline IF, ID, EX, M1..Mn, WB (n = MEM_STAGES, legal range 1..4).
//
//   Tracks {valid, rd, wr_en, is_load} for every instruction past ID in a
//   shift chain P0 = EX, P1..Pn = M1..Mn, P(n+1) = WB. Nothing stalls beyond ID,
//   so the chain shifts every clock.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN - when defined, o_stall_cnt / o_flush_cnt are saturating
//                        counters of stall cycles and redirect cycles. When
//                        undefined, both outputs are tied to zero and no
//                        counter flops exist.
//
// Ports:
//   i_clk, i_reset_n     clock, synchronous active-low reset
//   i_id_valid           ID holds a real instruction
//   i_id_rs1/i_id_rs2    ID source registers
//   i_id_rs_used         bit0 = rs1 read, bit1 = rs2 read
//   i_id_rd              ID destination register
//   i_id_reg_wr_en       ID instruction writes rd
//   i_id_is_load         ID instruction is a load
//   i_ex_redirect        taken branch/jump resolved in EX this cycle
//   o_stall              hold PC and IF/ID (combinational)
//   o_flush_if_id        clear IF/ID to NOP (combinational)
//   o_bubble_ex          load NOP into ID/EX (combinational)
//   o_fwd_sel_a/b        registered EX operand selects:
//                        00 regfile, 01 M1 ALU result, 10 WB result
//   o_stall_cnt          stall-cycle counter (optional)
//   o_flush_cnt          redirect-cycle counter (optional)
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_STAGES     = 1,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic [1:0]                i_id_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_reg_wr_en,
    input  logic                      i_id_is_load,
    input  logic                      i_ex_redirect,
    output logic                      o_stall,
    output logic                      o_flush_if_id,
    output logic                      o_bubble_ex,
    output logic [1:0]                o_fwd_sel_a,
    output logic [1:0]                o_fwd_sel_b,
    output logic [PERF_CNT_WIDTH-1:0] o_stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] o_flush_cnt
);

    // Tracked positions: EX, M1..Mn, WB.
    localparam int unsigned NPOS = MEM_STAGES + 2;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M1 = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Tracking chain state, index 0 is the youngest (EX).
    logic [NPOS-1:0]                     vld_q, vld_d;
    logic [NPOS-1:0]                     wen_q, wen_d;
    logic [NPOS-1:0]                     ld_q,  ld_d;
    logic [NPOS-1:0][REG_ADDR_WIDTH-1:0] rd_q,  rd_d;

    // Registered forwarding selects for the instruction currently in EX.
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    // Per-source resolution results.
    logic       found_a, found_b;
    logic       haz_a,   haz_b;
    logic [1:0] sel_a,   sel_b;

    logic       stall_c;
    logic       id_adv_c;

    // Action for a producer found at position pos, seen from a consumer in ID.
    // The consumer reaches EX when the producer reaches pos+1.
    // Returns {hazard, fwd_sel}.
    function automatic logic [2:0] decide(input int unsigned pos, input logic is_ld);
        logic [2:0] res;
        res = {1'b1, FWD_RF};
        if (pos == MEM_STAGES + 1) begin
            // Producer is writing back now; the register file is write-through.
            res = {1'b0, FWD_RF};
        end else if (pos == MEM_STAGES) begin
            // Producer will be in WB, where load data is also available.
            res = {1'b0, FWD_WB};
        end else if ((pos == 0) && !is_ld) begin
            // ALU result will sit in M1.
            res = {1'b0, FWD_M1};
        end
        return res;
    endfunction

    // Youngest-match search for both sources; older matches are ignored.
    always_comb begin : src_resolve
        found_a = 1'b0;
        found_b = 1'b0;
        haz_a   = 1'b0;
        haz_b   = 1'b0;
        sel_a   = FWD_RF;
        sel_b   = FWD_RF;
        for (int unsigned j = 0; j < NPOS; j++) begin
            if (!found_a && vld_q[j] && wen_q[j] && i_id_rs_used[0] &&
                (i_id_rs1 != '0) && (rd_q[j] == i_id_rs1)) begin
                found_a        = 1'b1;
                {haz_a, sel_a} = decide(j, ld_q[j]);
            end
            if (!found_b && vld_q[j] && wen_q[j] && i_id_rs_used[1] &&
                (i_id_rs2 != '0) && (rd_q[j] == i_id_rs2)) begin
                found_b        = 1'b1;
                {haz_b, sel_b} = decide(j, ld_q[j]);
            end
        end
    end

    // Redirect overrides stall: the ID instruction is squashed anyway.
    always_comb begin : ctrl_comb
        stall_c  = i_id_valid && (haz_a || haz_b) && !i_ex_redirect;
        id_adv_c = i_id_valid && !stall_c && !i_ex_redirect;
    end

    // Next-state for the tracking chain and forwarding selects.
    always_comb begin : chain_next
        vld_d   = {vld_q[NPOS-2:0], id_adv_c};
        wen_d   = {wen_q[NPOS-2:0], id_adv_c && i_id_reg_wr_en};
        ld_d    = {ld_q[NPOS-2:0],  id_adv_c && i_id_is_load};
        rd_d    = {rd_q[NPOS-2:0],  i_id_rd};
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_adv_c) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge i_clk) begin : chain_reg
        if (!i_reset_n) begin
            vld_q   <= '0;
            wen_q   <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            vld_q   <= vld_d;
            wen_q   <= wen_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign o_stall       = stall_c;
    assign o_flush_if_id = i_ex_redirect;
    assign o_bubble_ex   = stall_c || i_ex_redirect;
    assign o_fwd_sel_a   = fwd_a_q;
    assign o_fwd_sel_b   = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin : perf_next
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_CNT_WIDTH'(1);
        end
        if (i_ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin : perf_reg
        if (!i_reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
